sine_duty_gen: RTL and testbench
================================

// Module: sine_duty_gen
// PURPOSE
//  Three-phase sine duty generator. Feeds the 10-bit A/B/C duty inputs of the centre-aligned
//  three-phase PWM stage and recomputes all three duties once per PWM period, triggered by that
//  stage's one-clock Sync_Out pulse. Uses a phase accumulator, a quarter-wave sine LUT and an
//  amplitude multiplier, time-shared serially across the three phases.
// PARAMETERS
//  PHASE_W  24  phase accumulator width; one full turn is 2^PHASE_W
//  LUT_AW   8   quarter-wave LUT address width (2^LUT_AW entries)
//  DUTY_W   10  duty width; must match the PWM stage counter width
// PORTS
//  Clk        in   1        system clock; all logic on the rising edge
//  Reset      in   1        synchronous, active-low reset
//  Sync_In    in   1        one-clock pulse per PWM period (the PWM stage's Sync_Out)
//  Enable     in   1        1 = run; 0 = hold phase and commit mid-scale duties
//  Freq       in   PHASE_W  phase increment per accepted Sync_In (unsigned, wraps)
//  Amplitude  in   10       unsigned scale; 1023 is full scale (~1.0)
//  A, B, C    out  DUTY_W   duty words to the PWM stage; 0 deg / 120 deg / 240 deg
//  Busy       out  1        high from acceptance until the commit cycle, inclusive
//  Update     out  1        one-clock pulse in the cycle A/B/C take their new values
// BEHAVIOUR
//  - Reset (Reset==0 at a clock edge): Phase=0, A=B=C=512, Busy=0, Update=0, state IDLE.
//    A reset during a computation aborts it. No commit happens and the outputs go to 512.
//  - States: IDLE -> CALC_A -> CALC_B -> CALC_C -> COMMIT -> IDLE. Each CALC state lasts
//    2 clocks: a registered LUT read, then a registered multiply.
//  - Acceptance: Sync_In==1 in IDLE. At the same edge, Freq, Amplitude and Enable are captured
//    into holding registers. If the captured Enable is 1, Phase <= Phase + Freq (mod 2^PHASE_W).
//    Input changes after acceptance do not affect the computation in progress.
//  - A Sync_In pulse seen while Busy==1 is ignored. It is not queued and does not advance Phase.
//  - Phase offsets: B uses Phase + 0x555555 and C uses Phase + 0xAAAAAB. For other PHASE_W
//    values use round(2^PHASE_W/3) and round(2*2^PHASE_W/3). All sums wrap.
//  - Index: q = top 2 bits of the phase word; i = the next LUT_AW bits.
//    LUT entry Q(i) = round(511*sin(pi/2*(i+0.5)/2^LUT_AW)), giving a range of 0..511.
//  - Quadrant mapping: q=0 gives +Q(i); q=1 gives +Q(~i); q=2 gives -Q(i); q=3 gives -Q(~i).
//  - Scaling: s = sign * ((Q*Amplitude) >> 10), using a 19-bit unsigned product. s is in
//    -510..+510.
//  - Duty = 512 + s, which lies in 2..1022 and never saturates in base mode. If the captured
//    Enable is 0, all three duties are 512.
//  - Latency: with Sync_In accepted at edge 0, the COMMIT edge is edge 7. At that edge Update
//    goes high for one clock and A/B/C change together. Busy falls at edge 8.
//    A/B/C are never partially updated.
//  - Timing budget: latency is far below the PWM half-period (1023 clocks), so new duties are
//    in place before the PWM stage's next turnaround latch.
// CONFIGURATION
//  SINE_THIRD_HARMONIC_EN
//  - Defined: min/max common-mode injection. COMMIT is preceded by one extra cycle (MIX), so
//    the COMMIT edge becomes edge 8.
//    offset = (max(sA,sB,sC) + min(sA,sB,sC)) >>> 1, using a floored arithmetic shift.
//    Duty_x = clamp(512 + s_x - offset, 0, 1023). This raises usable line voltage by ~15%.
//  - Undefined: Duty_x = 512 + s_x, with no MIX state and the COMMIT edge at edge 7.
// TESTING
//  - Reset: Reset=0 for 2 clocks, then 1 -> A=B=C=512, Busy=0, Update=0, and no Update
//    without Sync_In.
//  - Static phase: Freq=0, Amplitude=1023, one Sync_In -> Update at edge 7; A=513, B~954, C~70
//    (exact values per the LUT reference model).
//  - Quarter step: Freq=0x400000, Amplitude=1023 -> successive Updates give A=1022, 511, 2, 513.
//    The fourth Update shows the wrap back to phase 0.
//  - Busy drop: two Sync_In pulses 3 clocks apart -> exactly one Update, and Phase advances by
//    Freq once.
//  - Enable=0 with Freq=0x400000 -> Update with A=B=C=512 and Phase unchanged. Re-enabling
//    resumes from the held Phase.
//  - Abort: Reset=0 at edge 4 after acceptance -> no Update pulse, A=B=C=512, Busy=0.
//    With SINE_THIRD_HARMONIC_EN, phase 90 deg and Amplitude=1023 -> A~895, COMMIT at edge 8.

Source files
------------

// File: rtl/sine_duty_gen.sv
// sine_duty_gen: three-phase sine duty generator for the centre-aligned PWM stage.
// Recomputes A/B/C once per PWM period from a phase accumulator and quarter-wave LUT.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      synchronous, active-low
//   Sync_In    one-clock pulse per PWM period; starts a computation when idle
//   Enable     1 = run, 0 = hold phase and commit mid-scale duties
//   Freq       phase increment per accepted Sync_In
//   Amplitude  unsigned scale, 1023 = full scale
//   A, B, C    duty words at 0 / 120 / 240 degrees
//   Busy       high from acceptance through the commit cycle
//   Update     one-clock pulse when A/B/C take new values
//
// Build option: define SINE_THIRD_HARMONIC_EN for min/max common-mode injection
// (adds a MIX cycle before COMMIT and clamps the duties).

module sine_duty_gen #(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8,
  parameter int DUTY_W  = 10
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Sync_In,
  input  logic               Enable,
  input  logic [PHASE_W-1:0] Freq,
  input  logic [9:0]         Amplitude,
  output logic [DUTY_W-1:0]  A,
  output logic [DUTY_W-1:0]  B,
  output logic [DUTY_W-1:0]  C,
  output logic               Busy,
  output logic               Update
);

  localparam int     LUT_N = 2 ** LUT_AW;
  localparam longint TURN  = 64'sd1 <<< PHASE_W;
  localparam logic [PHASE_W-1:0] OFF_B = PHASE_W'((TURN + 1) / 3);
  localparam logic [PHASE_W-1:0] OFF_C = PHASE_W'((2 * TURN + 1) / 3);
  localparam int     MID   = 2 ** (DUTY_W - 1);
  localparam int     TOP   = 2 ** DUTY_W - 1;
  localparam int     VW    = DUTY_W + 3;

  // Quarter-wave entry round(511*sin(pi/2*(i+0.5)/N)), evaluated at
  // elaboration with a 2^-30 fixed-point Taylor series.
  function automatic logic [8:0] q_entry(input int idx);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint v;
    x    = (longint'(1686629713) * longint'(2 * idx + 1)) >>> (LUT_AW + 1);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 10; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    v = (sum * 511 + (64'sd1 <<< 29)) >>> 30;
    if (v > 511) v = 511;
    if (v < 0) v = 0;
    return 9'(v);
  endfunction

  function automatic logic [DUTY_W-1:0] duty_of(
    input logic signed [10:0] s,
    input logic signed [10:0] off
  );
    logic signed [VW-1:0] v;
    v = VW'(MID) + VW'(s) - VW'(off);
    if (v < 0) return '0;
    if (v > VW'(TOP)) return DUTY_W'(TOP);
    return DUTY_W'(v);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    CALC_A,
    CALC_B,
    CALC_C,
`ifdef SINE_THIRD_HARMONIC_EN
    MIX,
`endif
    COMMIT
  } state_t;

  state_t state;
  logic   step;

  logic [PHASE_W-1:0] phase;
  logic [9:0]         amp_r;
  logic               en_r;
  logic [8:0]         lut_q;
  logic               sign_q;
  logic signed [10:0] sa;
  logic signed [10:0] sb;
  logic signed [10:0] sc;

  logic [8:0] lut [LUT_N];

  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    localparam logic [8:0] QV = q_entry(g);
    assign lut[g] = QV;
  end

  logic [PHASE_W-1:0]          pw_off;
  logic [1:0]                  q;
  logic [LUT_AW-1:0]           i_raw;
  logic [LUT_AW-1:0]           idx;
  logic [PHASE_W-LUT_AW-3:0]   pw_unused;

  always_comb begin
    pw_off = '0;
    case (state)
      CALC_B:  pw_off = OFF_B;
      CALC_C:  pw_off = OFF_C;
      default: pw_off = '0;
    endcase
    {q, i_raw, pw_unused} = phase + pw_off;
    // odd quadrants run the quarter wave backwards
    idx = q[0] ? ~i_raw : i_raw;
  end

  logic [8:0]         mag;
  logic [9:0]         prod_unused;
  logic signed [10:0] s_new;

  always_comb begin
    {mag, prod_unused} = lut_q * amp_r;
    s_new = sign_q ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
  end

`ifdef SINE_THIRD_HARMONIC_EN
  logic signed [10:0] off_r;
  logic signed [10:0] mx;
  logic signed [10:0] mn;
  logic signed [11:0] msum;
  logic signed [10:0] off_new;

  always_comb begin
    mx = sa;
    if (sb > mx) mx = sb;
    if (sc > mx) mx = sc;
    mn = sa;
    if (sb < mn) mn = sb;
    if (sc < mn) mn = sc;
    msum    = {mx[10], mx} + {mn[10], mn};
    off_new = 11'(msum >>> 1);
  end
`else
  logic signed [10:0] off_r;
  assign off_r = '0;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state  <= IDLE;
      step   <= 1'b0;
      phase  <= '0;
      amp_r  <= '0;
      en_r   <= 1'b0;
      lut_q  <= '0;
      sign_q <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      sc     <= '0;
      A      <= DUTY_W'(MID);
      B      <= DUTY_W'(MID);
      C      <= DUTY_W'(MID);
      Busy   <= 1'b0;
      Update <= 1'b0;
`ifdef SINE_THIRD_HARMONIC_EN
      off_r  <= '0;
`endif
    end else begin
      Update <= 1'b0;
      // Busy covers the commit cycle, so it drops one edge after Update
      if (Update) Busy <= 1'b0;
      case (state)
        IDLE: begin
          if (Sync_In && !Busy) begin
            amp_r <= Amplitude;
            en_r  <= Enable;
            if (Enable) phase <= phase + Freq;
            Busy  <= 1'b1;
            step  <= 1'b0;
            state <= CALC_A;
          end
        end
        CALC_A: begin
          step <= ~step;
          if (!step) begin
            lut_q  <= lut[idx];
            sign_q <= q[1];
          end else begin
            sa    <= s_new;
            state <= CALC_B;
          end
        end
        CALC_B: begin
          step <= ~step;
          if (!step) begin
            lut_q  <= lut[idx];
            sign_q <= q[1];
          end else begin
            sb    <= s_new;
            state <= CALC_C;
          end
        end
        CALC_C: begin
          step <= ~step;
          if (!step) begin
            lut_q  <= lut[idx];
            sign_q <= q[1];
          end else begin
            sc    <= s_new;
`ifdef SINE_THIRD_HARMONIC_EN
            state <= MIX;
`else
            state <= COMMIT;
`endif
          end
        end
`ifdef SINE_THIRD_HARMONIC_EN
        MIX: begin
          off_r <= off_new;
          state <= COMMIT;
        end
`endif
        COMMIT: begin
          if (en_r) begin
            A <= duty_of(sa, off_r);
            B <= duty_of(sb, off_r);
            C <= duty_of(sc, off_r);
          end else begin
            A <= DUTY_W'(MID);
            B <= DUTY_W'(MID);
            C <= DUTY_W'(MID);
          end
          Update <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          step  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sine_duty_gen.sv
// tb_sine_duty_gen: directed bench for sine_duty_gen.
// Expected duties are hand-derived from the quarter-wave LUT formula.

module tb_sine_duty_gen;

`ifdef SINE_THIRD_HARMONIC_EN
  localparam int LAT = 8;
  localparam int QA[4] = '{895, 511, 130, 513};
  localparam int QB[4] = '{130, 71, 895, 953};
  localparam int QC[4] = '{130, 953, 895, 71};
`else
  localparam int LAT = 7;
  localparam int QA[4] = '{1022, 511, 2, 513};
  localparam int QB[4] = '{257, 71, 767, 953};
  localparam int QC[4] = '{257, 953, 767, 71};
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Sync_In = 1'b0;
  logic        Enable = 1'b0;
  logic [23:0] Freq = '0;
  logic [9:0]  Amplitude = '0;
  logic [9:0]  A;
  logic [9:0]  B;
  logic [9:0]  C;
  logic        Busy;
  logic        Update;

  int total = 0;
  int bad = 0;

  sine_duty_gen dut (
    .Clk(Clk),
    .Reset(Reset),
    .Sync_In(Sync_In),
    .Enable(Enable),
    .Freq(Freq),
    .Amplitude(Amplitude),
    .A(A),
    .B(B),
    .C(C),
    .Busy(Busy),
    .Update(Update)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // pulse Sync_In for one clock and return edges until Update (-1 on timeout)
  task automatic run_once(output int lat);
    lat = -1;
    Sync_In = 1'b1;
    tick();
    Sync_In = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (Update === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int ups;
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    total++; if (A !== 10'd512) begin bad++; $display("FAIL reset_A: got %0d want 512", A); end
    total++; if (B !== 10'd512) begin bad++; $display("FAIL reset_B: got %0d want 512", B); end
    total++; if (C !== 10'd512) begin bad++; $display("FAIL reset_C: got %0d want 512", C); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    total++; if (Update !== 1'b0) begin bad++; $display("FAIL reset_upd: got %b want 0", Update); end
    ups = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (Update !== 1'b0) ups++;
    end
    total++; if (ups != 0) begin bad++; $display("FAIL idle_upd: got %0d want 0", ups); end
  endtask

  task automatic test_static();
    int lat;
    Freq = 24'h0;
    Amplitude = 10'd1023;
    Enable = 1'b1;
    run_once(lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL static_lat: got %0d want %0d", lat, LAT); end
    total++; if (A !== 10'd513) begin bad++; $display("FAIL static_A: got %0d want 513", A); end
    total++; if (B !== 10'd953) begin bad++; $display("FAIL static_B: got %0d want 953", B); end
    total++; if (C !== 10'd71) begin bad++; $display("FAIL static_C: got %0d want 71", C); end
    tick();
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL static_busy: got %b want 0", Busy); end
    total++; if (Update !== 1'b0) begin bad++; $display("FAIL static_upd: got %b want 0", Update); end
  endtask

  task automatic test_quarter();
    int lat;
    Freq = 24'h400000;
    Amplitude = 10'd1023;
    Enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_once(lat);
      total++; if (lat != LAT) begin bad++; $display("FAIL quarter_lat[%0d]: got %0d want %0d", k, lat, LAT); end
      total++; if (int'(A) != QA[k]) begin bad++; $display("FAIL quarter_A[%0d]: got %0d want %0d", k, A, QA[k]); end
      total++; if (int'(B) != QB[k]) begin bad++; $display("FAIL quarter_B[%0d]: got %0d want %0d", k, B, QB[k]); end
      total++; if (int'(C) != QC[k]) begin bad++; $display("FAIL quarter_C[%0d]: got %0d want %0d", k, C, QC[k]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int ups;
    int lat;
    int a_seen;
    int busy_lo;
    Freq = 24'h400000;
    Sync_In = 1'b1;
    tick();
    Sync_In = 1'b0;
    busy_lo = 0;
    tick();
    if (Busy !== 1'b1) busy_lo++;
    tick();
    if (Busy !== 1'b1) busy_lo++;
    Sync_In = 1'b1;
    tick();
    Sync_In = 1'b0;
    if (Busy !== 1'b1) busy_lo++;
    total++; if (busy_lo != 0) begin bad++; $display("FAIL b2b_busy: low %0d times want 0", busy_lo); end
    ups = 0;
    a_seen = -1;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (Update === 1'b1) begin
        ups++;
        a_seen = int'(A);
      end
    end
    total++; if (ups != 1) begin bad++; $display("FAIL b2b_updates: got %0d want 1", ups); end
    total++; if (a_seen != QA[0]) begin bad++; $display("FAIL b2b_A: got %0d want %0d", a_seen, QA[0]); end
    Freq = 24'h0;
    run_once(lat);
    total++; if (int'(A) != QA[0]) begin bad++; $display("FAIL b2b_phase: got %0d want %0d", A, QA[0]); end
    tick();
  endtask

  task automatic test_commit_edge();
    int lat;
    int ups;
    Freq = 24'h400000;
    run_once(lat);
    total++; if (int'(A) != QA[1]) begin bad++; $display("FAIL ce_A: got %0d want %0d", A, QA[1]); end
    Sync_In = 1'b1;
    tick();
    Sync_In = 1'b0;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL ce_busy: got %b want 0", Busy); end
    ups = 0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (Update !== 1'b0) ups++;
    end
    total++; if (ups != 0) begin bad++; $display("FAIL ce_updates: got %0d want 0", ups); end
    Freq = 24'h0;
    run_once(lat);
    total++; if (int'(A) != QA[1]) begin bad++; $display("FAIL ce_phase: got %0d want %0d", A, QA[1]); end
    tick();
  endtask

  task automatic test_enable();
    int lat;
    Enable = 1'b0;
    Freq = 24'h400000;
    run_once(lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL en_lat: got %0d want %0d", lat, LAT); end
    total++; if (A !== 10'd512) begin bad++; $display("FAIL en_A: got %0d want 512", A); end
    total++; if (B !== 10'd512) begin bad++; $display("FAIL en_B: got %0d want 512", B); end
    total++; if (C !== 10'd512) begin bad++; $display("FAIL en_C: got %0d want 512", C); end
    tick();
    Enable = 1'b1;
    Freq = 24'h0;
    run_once(lat);
    total++; if (int'(A) != QA[1]) begin bad++; $display("FAIL en_resume_A: got %0d want %0d", A, QA[1]); end
    total++; if (int'(B) != QB[1]) begin bad++; $display("FAIL en_resume_B: got %0d want %0d", B, QB[1]); end
    tick();
  endtask

  task automatic test_hold_inputs();
    int lat;
    Freq = 24'h0;
    Amplitude = 10'd1023;
    Enable = 1'b1;
    Sync_In = 1'b1;
    tick();
    Sync_In = 1'b0;
    Amplitude = 10'd0;
    Enable = 1'b0;
    Freq = 24'h400000;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (Update === 1'b1) begin
        lat = n;
        break;
      end
    end
    total++; if (lat != LAT) begin bad++; $display("FAIL hold_lat: got %0d want %0d", lat, LAT); end
    total++; if (int'(C) != QC[1]) begin bad++; $display("FAIL hold_C: got %0d want %0d", C, QC[1]); end
    tick();
    Amplitude = 10'd1023;
    Enable = 1'b1;
    Freq = 24'h0;
  endtask

  task automatic test_amplitude();
    int lat;
    Freq = 24'h0;
    Amplitude = 10'd512;
    run_once(lat);
    total++; if (A !== 10'd511) begin bad++; $display("FAIL amp512_A: got %0d want 511", A); end
    total++; if (B !== 10'd291) begin bad++; $display("FAIL amp512_B: got %0d want 291", B); end
    total++; if (C !== 10'd733) begin bad++; $display("FAIL amp512_C: got %0d want 733", C); end
    tick();
    Amplitude = 10'd0;
    run_once(lat);
    total++; if (B !== 10'd512) begin bad++; $display("FAIL amp0_B: got %0d want 512", B); end
    total++; if (C !== 10'd512) begin bad++; $display("FAIL amp0_C: got %0d want 512", C); end
    tick();
    Amplitude = 10'd1023;
  endtask

  task automatic test_abort();
    int lat;
    int ups;
    Freq = 24'h0;
    run_once(lat);
    total++; if (int'(B) != QB[1]) begin bad++; $display("FAIL pre_abort_B: got %0d want %0d", B, QB[1]); end
    tick();
    Freq = 24'h400000;
    Sync_In = 1'b1;
    tick();
    Sync_In = 1'b0;
    tick();
    tick();
    tick();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    ups = 0;
    for (int n = 0; n < 15; n++) begin
      if (Update !== 1'b0) ups++;
      tick();
    end
    total++; if (ups != 0) begin bad++; $display("FAIL abort_updates: got %0d want 0", ups); end
    total++; if (A !== 10'd512) begin bad++; $display("FAIL abort_A: got %0d want 512", A); end
    total++; if (B !== 10'd512) begin bad++; $display("FAIL abort_B: got %0d want 512", B); end
    total++; if (C !== 10'd512) begin bad++; $display("FAIL abort_C: got %0d want 512", C); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", Busy); end
    Freq = 24'h0;
    run_once(lat);
    total++; if (int'(A) != QA[3]) begin bad++; $display("FAIL abort_phase: got %0d want %0d", A, QA[3]); end
    tick();
  endtask

  initial begin
    test_reset();
    test_static();
    test_quarter();
    test_back_to_back();
    test_commit_edge();
    test_enable();
    test_hold_inputs();
    test_amplitude();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
